// File: rtl/computer_player_pkg.sv
// Shared definitions for the computer opponent: FSM state encoding and the
// constants of the 10-bit decision LFSR (x^10 + x^7 + 1, Fibonacci form).
package computer_player_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWait    = 2'd1,
    StHold    = 2'd2,
    StRelease = 2'd3
  } state_e;

  localparam int unsigned LfsrW = 10;
  // Tap bit indices for the x^10 and x^7 terms.
  localparam int unsigned LfsrTapA = 9;
  localparam int unsigned LfsrTapB = 6;
  localparam logic [LfsrW-1:0] LfsrSeed = 10'h001;

endpackage

// File: rtl/lfsr10.sv
// 10-bit Fibonacci LFSR (x^10 + x^7 + 1) used as the press-decision random source.
// Ports:
//   clk     - system clock, rising edge
//   reset   - asynchronous active-low reset, loads the seed
//   advance - shift one step on this cycle's edge
//   value   - current LFSR state (never zero, since the seed is non-zero)
module lfsr10
  import computer_player_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  output logic [LfsrW-1:0] value
);

  logic             feedback;
  logic [LfsrW-1:0] value_d;

  always_comb begin
    feedback = value[LfsrTapA] ^ value[LfsrTapB];
    value_d  = advance ? {value[LfsrW-2:0], feedback} : value;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= LfsrSeed;
    end else begin
      value <= value_d;
    end
  end

endmodule

// File: rtl/computer_player.sv
// Computer opponent: at every decision tick it may press a virtual button, with
// the press probability set by the difficulty switches. A press is held for
// HOLD_CYC cycles and always followed by HOLD_CYC cycles of release, so each
// press gives a distinct edge downstream.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   enable     - opponent active (level)
//   game_over  - game finished, stops new presses (level)
//   difficulty - press-probability threshold
//   press      - registered virtual button level, high only while holding
//   presses    - saturating count of completed (or aborted) presses
module computer_player
  import computer_player_pkg::*;
#(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned HOLD_CYC = 2_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       game_over,
  input  logic [8:0] difficulty,
  output logic       press,
  output logic [7:0] presses
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CntW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(HOLD_CYC - 1);

  logic [PreW-1:0]  pre_q, pre_d;
  logic             tick;
  logic [LfsrW-1:0] lfsr;
  logic             hit;
  logic             active;
  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             press_q, press_d;
  logic [7:0]       presses_q, presses_d;
  logic             press_done;

  // Prescaler: free-running in every state.
  always_comb begin
    tick  = (pre_q == PreLast);
    pre_d = tick ? '0 : pre_q + PreW'(1);
  end

  lfsr10 u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .advance(tick),
    .value  (lfsr)
  );

  // Decision uses the pre-advance LFSR value; all-ones and zero are forced
  // because the compare alone cannot reach "always".
  always_comb begin
    if (difficulty == 9'h1FF) begin
      hit = 1'b1;
    end else if (difficulty == 9'h000) begin
      hit = 1'b0;
    end else begin
      hit = (lfsr[9:1] < difficulty);
    end
  end

  assign active = enable && !game_over;

  always_comb begin
    state_d    = state_q;
    press_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (active) state_d = StWait;
      end
      StWait: begin
        if (!active) begin
          state_d = StIdle;
        end else if (tick && hit) begin
          state_d = StHold;
        end
      end
      StHold: begin
        // An abort still counts as a press and still goes through release.
        if (!active || (cnt_q == CntLast)) begin
          state_d    = StRelease;
          press_done = 1'b1;
        end
      end
      StRelease: begin
        if (cnt_q == CntLast) state_d = active ? StWait : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Shared hold/release counter, cleared on every state change.
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == StHold) || (state_q == StRelease)) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = '0;
    end
  end

  always_comb begin
    press_d   = (state_d == StHold);
    presses_d = presses_q;
    if (press_done && (presses_q != 8'hFF)) presses_d = presses_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q     <= '0;
      state_q   <= StIdle;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      presses_q <= 8'h00;
    end else begin
      pre_q     <= pre_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      presses_q <= presses_d;
    end
  end

  assign press   = press_q;
  assign presses = presses_q;

endmodule

// File: tb/tb_computer_player.sv
// Scoreboard bench for computer_player (TICK_DIV=4, HOLD_CYC=2). The driver
// applies inputs on the falling edge, steps a behavioural model and queues the
// expected post-edge outputs; the monitor pops and compares after each rising edge.
module tb_computer_player;
  import computer_player_pkg::*;

  localparam int unsigned TickDiv = 4;
  localparam int unsigned HoldCyc = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       game_over;
  logic [8:0] difficulty;
  logic       press;
  logic [7:0] presses;

  computer_player #(
    .TICK_DIV(TickDiv),
    .HOLD_CYC(HoldCyc)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .game_over (game_over),
    .difficulty(difficulty),
    .press     (press),
    .presses   (presses)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       press;
    logic [7:0] presses;
    logic [9:0] lfsr;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Behavioural model: phase 0 idle, 1 waiting, 2 holding, 3 releasing.
  int         m_phase;
  int         m_left;
  int         m_cyc;
  int         m_presses;
  logic [9:0] m_lfsr;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void fail_now(string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endfunction

  function automatic void model_step();
    bit tick;
    bit hit;
    bit go_on;
    if (!reset) begin
      m_phase   = 0;
      m_left    = 0;
      m_cyc     = 0;
      m_presses = 0;
      m_lfsr    = 10'h001;
      return;
    end
    tick = ((m_cyc % TickDiv) == (TickDiv - 1));
    if (difficulty == 9'h1FF) hit = 1'b1;
    else if (difficulty == 9'h000) hit = 1'b0;
    else hit = (int'(m_lfsr >> 1) < int'(difficulty));
    go_on = enable && !game_over;
    case (m_phase)
      0: if (go_on) m_phase = 1;
      1: begin
        if (!go_on) m_phase = 0;
        else if (tick && hit) begin
          m_phase = 2;
          m_left  = HoldCyc;
        end
      end
      2: begin
        m_left--;
        if (!go_on || m_left == 0) begin
          m_phase = 3;
          m_left  = HoldCyc;
          if (m_presses < 255) m_presses++;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) m_phase = go_on ? 1 : 0;
      end
    endcase
    if (tick) m_lfsr = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    m_cyc++;
  endfunction

  task automatic cycle(input logic rst, input logic en, input logic go, input logic [8:0] d);
    exp_t e;
    @(negedge clk);
    reset      = rst;
    enable     = en;
    game_over  = go;
    difficulty = d;
    model_step();
    e.press   = (m_phase == 2);
    e.presses = 8'(m_presses);
    e.lfsr    = m_lfsr;
    exp_q.push_back(e);
  endtask

  task automatic reset_pulse();
    cycle(1'b0, 1'b0, 1'b0, 9'h000);
    cycle(1'b0, 1'b0, 1'b0, 9'h000);
  endtask

  // Run with full difficulty until the model is in its first hold cycle.
  task automatic run_to_hold(input string name);
    int n;
    n = 0;
    while (!(m_phase == 2 && m_left == HoldCyc) && n < 40) begin
      cycle(1'b1, 1'b1, 1'b0, 9'h1FF);
      n++;
    end
    if (n >= 40) fail_now(name);
  endtask

  initial begin : monitor
    exp_t e;
    bit   seen;
    bit   prev;
    int   low_run;
    seen    = 1'b0;
    prev    = 1'b0;
    low_run = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("press", 32'(press), 32'(e.press));
        check("presses", 32'(presses), 32'(e.presses));
        check("lfsr", 32'(dut.u_lfsr.value), 32'(e.lfsr));
        if (!reset) begin
          seen    = 1'b0;
          low_run = 0;
        end else if (press) begin
          if (!prev && seen) check("press_gap_ok", 32'(low_run >= int'(HoldCyc)), 32'd1);
          seen    = 1'b1;
          low_run = 0;
        end else begin
          low_run++;
        end
        prev = press;
      end
    end
  end

  initial begin : driver
    logic       en;
    logic       go;
    logic [8:0] d;
    int         first;

    reset      = 1'b0;
    enable     = 1'b0;
    game_over  = 1'b0;
    difficulty = 9'h000;

    // Reset state.
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 9'h000);
    @(posedge clk);
    #2;
    check("rst_press", 32'(press), 32'd0);
    check("rst_presses", 32'(presses), 32'd0);
    check("rst_lfsr", 32'(dut.u_lfsr.value), 32'h001);
    check("rst_state", 32'(dut.state_q), 32'(StIdle));

    // Difficulty zero never presses.
    repeat (2000) cycle(1'b1, 1'b1, 1'b0, 9'h000);
    @(posedge clk);
    #2;
    check("diff0_presses", 32'(presses), 32'd0);

    // Full difficulty: press after every usable tick.
    reset_pulse();
    repeat (200) cycle(1'b1, 1'b1, 1'b0, 9'h1FF);

    // game_over in the first hold cycle.
    reset_pulse();
    run_to_hold("hold_wait_go");
    repeat (10) cycle(1'b1, 1'b1, 1'b1, 9'h1FF);
    @(posedge clk);
    #2;
    check("go_presses", 32'(presses), 32'd1);
    check("go_state", 32'(dut.state_q), 32'(StIdle));
    check("go_press", 32'(press), 32'd0);

    // Saturation.
    reset_pulse();
    repeat (3000) cycle(1'b1, 1'b1, 1'b0, 9'h1FF);
    @(posedge clk);
    #2;
    check("sat_presses", 32'(presses), 32'hFF);

    // Randomised inputs, including mid-window difficulty changes and resets.
    reset_pulse();
    en = 1'b1;
    go = 1'b0;
    d  = 9'($urandom_range(1, 510));
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 3) en = ~en;
      if ($urandom_range(0, 99) < 2) go = ~go;
      if ($urandom_range(0, 99) < 10) begin
        case ($urandom_range(0, 4))
          0:       d = 9'h000;
          1:       d = 9'h1FF;
          default: d = 9'($urandom_range(1, 510));
        endcase
      end
      cycle(($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1, en, go, d);
    end

    // Asynchronous reset between edges in the middle of a hold.
    reset_pulse();
    run_to_hold("hold_wait_rst");
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_press", 32'(press), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 9'h1FF);
    cycle(1'b0, 1'b1, 1'b0, 9'h1FF);
    cycle(1'b1, 1'b1, 1'b0, 9'h1FF);
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #2;
      if (press && first == 0) first = k;
      cycle(1'b1, 1'b1, 1'b0, 9'h1FF);
    end
    check("first_press_edge", 32'(first), 32'(TickDiv));

    repeat (2) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
